// File: rtl/rotate_square.sv
// Rotating-square animation for a 4-digit seven-segment display (active-low {dp,g,f,e,d,c,b,a}).
// Optional ROTATE_SQUARE_DP_EN: the lit digit's dp shows the rotation direction.
module rotate_square #(
    parameter int POWER = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clockwise,
    output logic [7:0] in0,
    output logic [7:0] in1,
    output logic [7:0] in2,
    output logic [7:0] in3
);

    localparam logic [7:0] TOP   = 8'h9C;
    localparam logic [7:0] BOT   = 8'hA3;
    localparam logic [7:0] BLANK = 8'hFF;

    localparam logic [POWER-1:0] CNT_MAX = {POWER{1'b1}};
    localparam logic [POWER-1:0] CNT_ONE = 1;

    logic [POWER-1:0] cnt;
    logic [2:0]       pos;
    logic             tick;
    logic             dp_n;
    logic [7:0]       top_pat;
    logic [7:0]       bot_pat;

    assign tick = enable && (cnt == CNT_MAX);

    // Prescaler wraps every 2**POWER enabled cycles; position steps only on that wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            pos <= 3'd0;
        end else if (enable) begin
            if (tick) begin
                cnt <= '0;
                pos <= clockwise ? pos + 3'd1 : pos - 3'd1;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

`ifdef ROTATE_SQUARE_DP_EN
    assign dp_n = ~clockwise;
`else
    assign dp_n = 1'b1;
`endif

    assign top_pat = {dp_n, TOP[6:0]};
    assign bot_pat = {dp_n, BOT[6:0]};

    // Positions 0..3 sweep the top row leftmost to rightmost, 4..7 come back along the bottom.
    always_comb begin
        in0 = BLANK;
        in1 = BLANK;
        in2 = BLANK;
        in3 = BLANK;
        case (pos)
            3'd0: in3 = top_pat;
            3'd1: in2 = top_pat;
            3'd2: in1 = top_pat;
            3'd3: in0 = top_pat;
            3'd4: in0 = bot_pat;
            3'd5: in1 = bot_pat;
            3'd6: in2 = bot_pat;
            default: in3 = bot_pat;
        endcase
    end

endmodule

// File: tb/tb_rotate_square.sv
// Self-checking bench for rotate_square (POWER=2): vector table, corner sequences, random run vs model.
// Honours ROTATE_SQUARE_DP_EN the same way as the design.
module tb_rotate_square;

    localparam int POWER  = 2;
    localparam int PERIOD = 1 << POWER;

    localparam logic [31:0] P0 = 32'h9C_FF_FF_FF;
    localparam logic [31:0] P1 = 32'hFF_9C_FF_FF;
    localparam logic [31:0] P2 = 32'hFF_FF_9C_FF;
    localparam logic [31:0] P4 = 32'hFF_FF_FF_A3;
    localparam logic [31:0] P6 = 32'hFF_A3_FF_FF;
    localparam logic [31:0] P7 = 32'hA3_FF_FF_FF;

    typedef struct {
        logic        rst;
        logic        en;
        logic        cw;
        logic [31:0] exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       clockwise;
    logic [7:0] in0, in1, in2, in3;

    int checks;
    int errors;
    int m_pos;
    int m_edges;
    vec_t vecs[$];

    rotate_square #(.POWER(POWER)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .clockwise(clockwise),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .in3(in3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // With the dp option, the one lit (non-FF) digit gets bit7 cleared while clockwise=1.
    function automatic logic [31:0] dp_adjust(input logic [31:0] w, input logic cw);
        logic [31:0] r;
        r = w;
`ifdef ROTATE_SQUARE_DP_EN
        for (int d = 0; d < 4; d++)
            if (cw && r[d*8 +: 8] != 8'hFF) r[d*8+7] = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [31:0] model_word(input int p, input logic cw);
        logic [31:0] w;
        int d;
        w = '1;
        d = (p < 4) ? 3 - p : p - 4;
        w[d*8 +: 8] = (p < 4) ? 8'h9C : 8'hA3;
        return dp_adjust(w, cw);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] expected);
        logic [31:0] actual;
        actual = {in3, in2, in1, in0};
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, then compare 1 ns later.
    task automatic applyStimulus(input logic r, input logic e, input logic c);
        reset     = r;
        enable    = e;
        clockwise = c;
        @(posedge clk);
        if (r) begin
            m_pos   = 0;
            m_edges = 0;
        end else if (e) begin
            m_edges++;
            if (m_edges % PERIOD == 0) m_pos = c ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
        end
        #1;
        checkOutput("model", model_word(m_pos, c));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_pos     = 0;
        m_edges   = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        clockwise = 1'b1;
        #1;
        checkOutput("reset_no_clock", dp_adjust(P0, 1'b1));

        vecs.push_back('{1'b1, 1'b1, 1'b1, P0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, P0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, P0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, P0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, P0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, P1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, P1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, P1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, P1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, P1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, P1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, P2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P2});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, P7});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].cw);
            checkOutput($sformatf("vec%0d", i), dp_adjust(vecs[i].exp, vecs[i].cw));
        end

        // Clockwise from reset: bottom-right at edge 16, home again at edge 32.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (i == 16) checkOutput("cw_edge16", dp_adjust(P4, 1'b1));
            if (i == 32) checkOutput("cw_edge32", dp_adjust(P0, 1'b1));
        end

        // Async reset in the middle of a clock period, then a full prescaler period to the next step.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        #4;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", dp_adjust(P0, 1'b1));
        m_pos   = 0;
        m_edges = 0;
        #2;
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            if (i == 3) checkOutput("post_reset_edge3", dp_adjust(P0, 1'b1));
            if (i == 4) checkOutput("post_reset_edge4", dp_adjust(P1, 1'b1));
        end

        // Freeze with a partially filled prescaler; resuming must finish that count.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("hold_end", dp_adjust(P0, 1'b1));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("resume_edge3", dp_adjust(P0, 1'b1));
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("resume_edge4", dp_adjust(P1, 1'b1));

        // Counter-clockwise from reset: wraps backwards to pos7 first.
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            if (i == 4)  checkOutput("ccw_edge4", dp_adjust(P7, 1'b0));
            if (i == 8)  checkOutput("ccw_edge8", dp_adjust(P6, 1'b0));
            if (i == 32) checkOutput("ccw_edge32", dp_adjust(P0, 1'b0));
        end

`ifdef ROTATE_SQUARE_DP_EN
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("dp_cw", 32'h1C_FF_FF_FF);
        clockwise = 1'b0;
        #1;
        checkOutput("dp_toggle", 32'h9C_FF_FF_FF);
`endif

        // Random run: enable mostly on, direction free, occasional reset.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                          logic'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
